// File: rtl/dc_avg_ctrl.sv
// Sequencer for the moving-average DC-removal stage: strobes the averager, blanks output
// while the window fills, registers the result. Optional DC_AVG_CTRL_BYPASS_EN adds bypass_i.
module dc_avg_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SAMPLES = 128,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             sample_vld_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] avg_data_i,
`ifdef DC_AVG_CTRL_BYPASS_EN
  input  logic             bypass_i,
`endif
  output logic             avg_clr_o,
  output logic             avg_start_o,
  output logic             avg_strobe_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             filling_o,
  output logic             drop_o
);

  localparam int unsigned CntW = $clog2(SAMPLES) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(SAMPLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StClear, StFill, StRun} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] fill_cnt_q, fill_cnt_d;
  logic clr_q, clr_d;
  logic start_q, start_d;
  logic filling_q, filling_d;
  logic drop_q, drop_d;
  logic valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Per-strobe pipeline: strobe flag, "may assert valid" tag, bypass tag, captured sample.
  logic [LATENCY-1:0] stb_q, stb_d;
  logic [LATENCY-1:0] elig_q, elig_d;
  logic [LATENCY-1:0] byp_q, byp_d;
  logic [WIDTH-1:0] smp_q [LATENCY];
  logic [WIDTH-1:0] smp_d [LATENCY];

  logic bypass;
  logic active;
  logic accept;
  logic tap;

`ifdef DC_AVG_CTRL_BYPASS_EN
  assign bypass = bypass_i;
`else
  assign bypass = 1'b0;
`endif

  assign active = enable_i && ((state_q == StFill) || (state_q == StRun));
  assign accept = sample_vld_i && active;
  assign tap    = stb_q[LATENCY-1] && active;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable_i) state_d = StClear;
      StClear: state_d = enable_i ? StFill : StIdle;
      StFill: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (accept && (fill_cnt_q == LastCnt)) begin
          state_d = StRun;
        end
      end
      StRun:   if (!enable_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    clr_d     = (state_d == StIdle) || (state_d == StClear);
    start_d   = (state_d == StFill) || (state_d == StRun);
    filling_d = (state_d == StFill);
  end

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    drop_d     = drop_q;
    if (state_q == StClear) begin
      fill_cnt_d = '0;
      drop_d     = 1'b0;
    end else if (accept && (fill_cnt_q != FullCnt)) begin
      fill_cnt_d = fill_cnt_q + CntW'(1);
    end
    // A sample arriving in the same cycle as the clear is still reported as dropped.
    if (sample_vld_i && !accept) begin
      drop_d = 1'b1;
    end
  end

  always_comb begin
    stb_d     = '0;
    elig_d    = '0;
    byp_d     = '0;
    smp_d     = smp_q;
    smp_d[0]  = sample_i;
    stb_d[0]  = accept;
    elig_d[0] = (state_q == StRun) || bypass;
    byp_d[0]  = bypass;
    for (int i = 1; i < LATENCY; i++) begin
      stb_d[i]  = stb_q[i-1];
      elig_d[i] = elig_q[i-1];
      byp_d[i]  = byp_q[i-1];
      smp_d[i]  = smp_q[i-1];
    end
    // Leaving FILL/RUN discards everything still in flight.
    if (!active) begin
      stb_d = '0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (tap) begin
      data_d  = byp_q[LATENCY-1] ? smp_q[LATENCY-1] : avg_data_i;
      valid_d = elig_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      clr_q      <= 1'b1;
      start_q    <= 1'b0;
      filling_q  <= 1'b0;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      stb_q      <= '0;
      elig_q     <= '0;
      byp_q      <= '0;
      smp_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      clr_q      <= clr_d;
      start_q    <= start_d;
      filling_q  <= filling_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      stb_q      <= stb_d;
      elig_q     <= elig_d;
      byp_q      <= byp_d;
      smp_q      <= smp_d;
    end
  end

  assign avg_clr_o    = clr_q;
  assign avg_start_o  = start_q;
  assign avg_strobe_o = accept;
  assign filling_o    = filling_q;
  assign drop_o       = drop_q;
  assign valid_o      = valid_q;
  assign data_o       = data_q;

endmodule

// File: tb/tb_dc_avg_ctrl.sv
// Directed bench for dc_avg_ctrl (WIDTH=16, SAMPLES=128, LATENCY=1).
module tb_dc_avg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        vld;
  logic [15:0] smp;
  logic [15:0] avg;
  logic        bypass;
  logic        avg_clr, avg_start, avg_strobe, valid, filling, drop;
  logic [15:0] data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_stb = 0;
  int vcyc[$];
  logic [15:0] vdat[$];

  dc_avg_ctrl #(
    .WIDTH  (16),
    .SAMPLES(128),
    .LATENCY(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .sample_vld_i(vld),
    .sample_i    (smp),
    .avg_data_i  (avg),
`ifdef DC_AVG_CTRL_BYPASS_EN
    .bypass_i    (bypass),
`endif
    .avg_clr_o   (avg_clr),
    .avg_start_o (avg_start),
    .avg_strobe_o(avg_strobe),
    .data_o      (data),
    .valid_o     (valid),
    .filling_o   (filling),
    .drop_o      (drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (avg_strobe) n_stb++;
    if (valid) begin
      vcyc.push_back(cyc);
      vdat.push_back(data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] a);
    vld = 1'b1;
    avg = a;
    step();
    vld = 1'b0;
    step();
  endtask

  int b, s, pc, p129, p130, c0;

  initial begin
    bypass = 1'b0;
    rst = 1'b1; enable = 1'b0; vld = 1'b0; smp = '0; avg = '0;
    repeat (3) step();
    check_eq("rst_clr", avg_clr, 1);
    check_eq("rst_start", avg_start, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_filling", filling, 0);
    rst = 1'b0;
    step();

    // Fill the window, then two samples in RUN.
    b = vcyc.size(); s = n_stb;
    enable = 1'b1;
    step();
    check_eq("t2_clear_clr", avg_clr, 1);
    check_eq("t2_clear_filling", filling, 0);
    step();
    check_eq("t2_fill_clr", avg_clr, 0);
    check_eq("t2_fill_start", avg_start, 1);
    check_eq("t2_fill_filling", filling, 1);
    for (int k = 1; k <= 130; k++) begin
      if (k == 128) check_eq("t2_filling_before_128", filling, 1);
      if (k == 129) check_eq("t2_data_updates_in_fill", data, 28);
      if (k == 129) p129 = cyc;
      if (k == 130) p130 = cyc;
      vld = 1'b1;
      avg = 16'(k - 100);
      step();
      vld = 1'b0;
      if (k == 128) check_eq("t2_filling_after_128", filling, 0);
      if (k == 128) check_eq("t2_no_valid_after_128", vcyc.size() - b, 0);
      step();
    end
    step(); step();
    check_eq("t2_strobes", n_stb - s, 130);
    check_eq("t2_valid_count", vcyc.size() - b, 2);
    check_eq("t2_v129_cycle", vcyc[b], p129 + 2);
    check_eq("t2_v129_data", vdat[b], 29);
    check_eq("t2_v130_cycle", vcyc[b+1], p130 + 2);
    check_eq("t2_v130_data", vdat[b+1], 30);

    // Full-rate stream in RUN.
    b = vcyc.size(); s = n_stb; c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      vld = 1'b1;
      avg = 16'(200 + i - 1);
      step();
    end
    vld = 1'b0; avg = 16'd209;
    step(); step(); step();
    check_eq("t3_strobes", n_stb - s, 10);
    check_eq("t3_valid_count", vcyc.size() - b, 10);
    check_eq("t3_first_cycle", vcyc[b], c0 + 2);
    check_eq("t3_no_gaps", vcyc[b+9] - vcyc[b], 9);
    check_eq("t3_first_data", vdat[b], 200);
    check_eq("t3_last_data", vdat[b+9], 209);

    // Leaving flushes the pipeline; drop in IDLE; re-enable clears drop.
    b = vcyc.size();
    vld = 1'b1; avg = 16'd77;
    step();
    vld = 1'b0; enable = 1'b0;
    step();
    check_eq("t4_idle_clr", avg_clr, 1);
    check_eq("t4_idle_start", avg_start, 0);
    step(); step();
    check_eq("t4_flush_no_valid", vcyc.size() - b, 0);
    check_eq("t4_no_drop_on_leave", drop, 0);
    s = n_stb;
    vld = 1'b1;
    #1;
    check_eq("t4_idle_no_strobe", avg_strobe, 0);
    step();
    vld = 1'b0;
    check_eq("t4_drop_set", drop, 1);
    step();
    check_eq("t4_drop_sticky", drop, 1);
    check_eq("t4_strobe_count", n_stb - s, 0);
    enable = 1'b1;
    step();
    check_eq("t4_clear_clr", avg_clr, 1);
    step();
    check_eq("t4_clr_one_cycle", avg_clr, 0);
    check_eq("t4_drop_cleared", drop, 0);
    check_eq("t4_filling", filling, 1);

    // Abort the fill at 60, re-enable, a full window is needed again.
    for (int k = 1; k <= 60; k++) pulse(16'(k));
    vld = 1'b1; enable = 1'b0;
    #1;
    check_eq("t5_fall_no_strobe", avg_strobe, 0);
    step();
    vld = 1'b0;
    check_eq("t5_fall_drop", drop, 1);
    check_eq("t5_idle_clr", avg_clr, 1);
    repeat (4) step();
    enable = 1'b1;
    step();
    check_eq("t5_reclear_clr", avg_clr, 1);
    step();
    check_eq("t5_refill_clr", avg_clr, 0);
    check_eq("t5_refill_drop", drop, 0);
    check_eq("t5_refill_filling", filling, 1);
    b = vcyc.size();
    for (int k = 1; k <= 128; k++) pulse(16'(k));
    step();
    check_eq("t5_no_valid_in_fill", vcyc.size() - b, 0);
    check_eq("t5_filling_done", filling, 0);
    pc = cyc;
    vld = 1'b1; avg = 16'd500;
    step();
    vld = 1'b0;
    step(); step();
    check_eq("t5_valid_count", vcyc.size() - b, 1);
    check_eq("t5_valid_cycle", vcyc[b], pc + 2);
    check_eq("t5_valid_data", vdat[b], 500);

`ifdef DC_AVG_CTRL_BYPASS_EN
    // Bypass during FILL forwards sample_i with valid.
    enable = 1'b0;
    step();
    enable = 1'b1;
    step(); step();
    check_eq("t6_filling", filling, 1);
    b = vcyc.size(); pc = cyc;
    bypass = 1'b1; smp = 16'h1234; avg = 16'h0bad; vld = 1'b1;
    step();
    vld = 1'b0; smp = '0;
    step(); step();
    check_eq("t6_valid_count", vcyc.size() - b, 1);
    check_eq("t6_valid_cycle", vcyc[b], pc + 2);
    check_eq("t6_valid_data", vdat[b], 16'h1234);
    bypass = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
